dcache_wb: RTL and testbench

- Parametrised direct-mapped, write-back, write-allocate data cache between the memory stage and the line-wide memory model.
- Successor to the first-generation data cache, adding:
  - a registered request/response handshake
  - a proper eviction and refill state machine
  - word and byte stores with dirty tracking
  - a full-cache flush command

---
 rtl/dcache_wb.sv | 260 ++++++++++++++++++++++++++
 tb/tb_dcache_wb.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_wb.sv
// rtl/dcache_wb.sv - direct-mapped write-back, write-allocate data cache
// Line refill/eviction FSM with word/byte stores, dirty tracking and full flush.
module dcache_wb #(
  parameter int ADDR_WIDTH = 32,
  parameter int WORD_WIDTH = 32,
  parameter int LINE_WORDS = 4,
  parameter int NLINES     = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             req_valid,
  input  logic                             req_we,
  input  logic                             req_byte,
  input  logic [ADDR_WIDTH-1:0]            req_addr,
  input  logic [WORD_WIDTH-1:0]            req_wdata,
  input  logic                             flush,
  output logic                             stall,
  output logic                             rsp_valid,
  output logic                             rsp_hit,
  output logic [WORD_WIDTH-1:0]            rsp_rdata,
  output logic                             mem_req,
  output logic                             mem_we,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  output logic [LINE_WORDS*WORD_WIDTH-1:0] mem_wdata,
  input  logic [LINE_WORDS*WORD_WIDTH-1:0] mem_rdata,
  input  logic                             mem_rdy
);

  localparam int LINE_W = LINE_WORDS * WORD_WIDTH;
  localparam int OFF_W  = $clog2(LINE_W / 8);
  localparam int IDX_W  = $clog2(NLINES);
  localparam int TAG_W  = ADDR_WIDTH - IDX_W - OFF_W;
  localparam int BSEL_W = $clog2(WORD_WIDTH / 8);
  localparam logic [OFF_W-1:0] BMASK = OFF_W'(WORD_WIDTH / 8 - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WB,
    S_REFILL,
    S_RESPOND,
    S_FLUSH,
    S_FLUSH_WB
  } state_t;

  state_t                  r_state;
  logic [NLINES-1:0]       r_valid;
  logic [NLINES-1:0]       r_dirty;
  logic [TAG_W-1:0]        r_tags  [NLINES];
  logic [LINE_W-1:0]       r_lines [NLINES];
  logic                    r_we;
  logic                    r_byte;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [WORD_WIDTH-1:0]   r_wdata;
  logic [IDX_W-1:0]        r_fidx;

  logic [TAG_W-1:0]        w_req_tag;
  logic [IDX_W-1:0]        w_req_idx;
  logic [OFF_W-1:0]        w_req_off;
  logic [TAG_W-1:0]        w_lat_tag;
  logic [IDX_W-1:0]        w_lat_idx;
  logic [OFF_W-1:0]        w_lat_off;
  logic [LINE_W-1:0]       w_req_line;
  logic [LINE_W-1:0]       w_lat_line;
  logic [LINE_W-1:0]       w_fl_line;
  logic [TAG_W-1:0]        w_fl_tag;
  logic                    w_hit;
  logic                    w_victim_dirty;
  logic                    w_accept;
  logic                    w_fl_last;
  logic                    w_wr_en;
  logic                    w_tag_en;
  logic [IDX_W-1:0]        w_wr_idx;
  logic [LINE_W-1:0]       w_wr_line;

  function automatic logic [LINE_W-1:0] f_merge(
    input logic [LINE_W-1:0]     line,
    input logic [OFF_W-1:0]      off,
    input logic                  is_byte,
    input logic [WORD_WIDTH-1:0] wd
  );
    logic [LINE_W-1:0] l;
    int ws;
    int bs;
    l  = line;
    ws = int'(off >> BSEL_W);
    bs = int'(off & BMASK);
    if (is_byte) l[ws*WORD_WIDTH + bs*8 +: 8] = wd[7:0];
    else         l[ws*WORD_WIDTH +: WORD_WIDTH] = wd;
    return l;
  endfunction

  // Word accesses drop the byte-select bits; byte loads are zero-extended.
  function automatic logic [WORD_WIDTH-1:0] f_read(
    input logic [LINE_W-1:0] line,
    input logic [OFF_W-1:0]  off,
    input logic              is_byte
  );
    logic [WORD_WIDTH-1:0] w;
    int ws;
    int bs;
    ws = int'(off >> BSEL_W);
    bs = int'(off & BMASK);
    w  = line[ws*WORD_WIDTH +: WORD_WIDTH];
    if (is_byte) return WORD_WIDTH'(w[bs*8 +: 8]);
    return w;
  endfunction

  assign w_req_tag      = req_addr[ADDR_WIDTH-1 -: TAG_W];
  assign w_req_idx      = req_addr[OFF_W +: IDX_W];
  assign w_req_off      = req_addr[OFF_W-1:0];
  assign w_lat_tag      = r_addr[ADDR_WIDTH-1 -: TAG_W];
  assign w_lat_idx      = r_addr[OFF_W +: IDX_W];
  assign w_lat_off      = r_addr[OFF_W-1:0];
  assign w_req_line     = r_lines[w_req_idx];
  assign w_lat_line     = r_lines[w_lat_idx];
  assign w_fl_line      = r_lines[r_fidx];
  assign w_fl_tag       = r_tags[r_fidx];
  assign w_hit          = r_valid[w_req_idx] && (r_tags[w_req_idx] == w_req_tag);
  assign w_victim_dirty = r_valid[w_req_idx] && r_dirty[w_req_idx];
  assign w_accept       = (r_state == S_IDLE) && !flush && req_valid;
  assign w_fl_last      = (r_fidx == IDX_W'(NLINES - 1));

  // Single write port: store hit, refill, or post-refill store merge.
  always_comb begin
    w_wr_en   = 1'b0;
    w_tag_en  = 1'b0;
    w_wr_idx  = w_lat_idx;
    w_wr_line = mem_rdata;
    if (w_accept && w_hit && req_we) begin
      w_wr_en   = 1'b1;
      w_wr_idx  = w_req_idx;
      w_wr_line = f_merge(w_req_line, w_req_off, req_byte, req_wdata);
    end else if (r_state == S_REFILL && mem_rdy) begin
      w_wr_en  = 1'b1;
      w_tag_en = 1'b1;
    end else if (r_state == S_RESPOND && r_we) begin
      w_wr_en   = 1'b1;
      w_wr_line = f_merge(w_lat_line, w_lat_off, r_byte, r_wdata);
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en)  r_lines[w_wr_idx] <= w_wr_line;
    if (w_tag_en) r_tags[w_lat_idx] <= w_lat_tag;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_valid   <= '0;
      r_dirty   <= '0;
      r_we      <= 1'b0;
      r_byte    <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_fidx    <= '0;
      stall     <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_hit   <= 1'b0;
      rsp_rdata <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (flush) begin
            r_state <= S_FLUSH;
            r_fidx  <= '0;
            stall   <= 1'b1;
          end else if (req_valid) begin
            r_we    <= req_we;
            r_byte  <= req_byte;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            if (w_hit) begin
              rsp_valid <= 1'b1;
              rsp_hit   <= 1'b1;
              rsp_rdata <= f_read(w_req_line, w_req_off, req_byte);
              if (req_we) r_dirty[w_req_idx] <= 1'b1;
            end else begin
              stall   <= 1'b1;
              mem_req <= 1'b1;
              if (w_victim_dirty) begin
                r_state   <= S_WB;
                mem_we    <= 1'b1;
                mem_addr  <= {r_tags[w_req_idx], w_req_idx, OFF_W'(0)};
                mem_wdata <= w_req_line;
              end else begin
                r_state  <= S_REFILL;
                mem_we   <= 1'b0;
                mem_addr <= {w_req_tag, w_req_idx, OFF_W'(0)};
              end
            end
          end
        end
        S_WB: begin
          if (mem_rdy) begin
            r_dirty[w_lat_idx] <= 1'b0;
            r_state            <= S_REFILL;
            mem_we             <= 1'b0;
            mem_addr           <= {w_lat_tag, w_lat_idx, OFF_W'(0)};
          end
        end
        S_REFILL: begin
          if (mem_rdy) begin
            r_valid[w_lat_idx] <= 1'b1;
            r_dirty[w_lat_idx] <= 1'b0;
            mem_req            <= 1'b0;
            r_state            <= S_RESPOND;
          end
        end
        S_RESPOND: begin
          rsp_valid <= 1'b1;
          rsp_hit   <= 1'b0;
          rsp_rdata <= f_read(w_lat_line, w_lat_off, r_byte);
          if (r_we) r_dirty[w_lat_idx] <= 1'b1;
          stall     <= 1'b0;
          r_state   <= S_IDLE;
        end
        S_FLUSH: begin
          if (r_valid[r_fidx] && r_dirty[r_fidx]) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= {w_fl_tag, r_fidx, OFF_W'(0)};
            mem_wdata <= w_fl_line;
            r_state   <= S_FLUSH_WB;
          end else begin
            r_valid[r_fidx] <= 1'b0;
            r_dirty[r_fidx] <= 1'b0;
            if (w_fl_last) begin
              r_state <= S_IDLE;
              stall   <= 1'b0;
            end else begin
              r_fidx <= r_fidx + 1'b1;
            end
          end
        end
        S_FLUSH_WB: begin
          if (mem_rdy) begin
            mem_req         <= 1'b0;
            r_valid[r_fidx] <= 1'b0;
            r_dirty[r_fidx] <= 1'b0;
            if (w_fl_last) begin
              r_state <= S_IDLE;
              stall   <= 1'b0;
            end else begin
              r_fidx  <= r_fidx + 1'b1;
              r_state <= S_FLUSH;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_wb.sv
// tb/tb_dcache_wb.sv - self-checking bench for dcache_wb against a word-level memory model
module tb_dcache_wb;

  logic         clk;
  logic         reset;
  logic         req_valid;
  logic         req_we;
  logic         req_byte;
  logic [31:0]  req_addr;
  logic [31:0]  req_wdata;
  logic         flush;
  logic         stall;
  logic         rsp_valid;
  logic         rsp_hit;
  logic [31:0]  rsp_rdata;
  logic         mem_req;
  logic         mem_we;
  logic [31:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_rdy;

  dcache_wb dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_we(req_we), .req_byte(req_byte),
    .req_addr(req_addr), .req_wdata(req_wdata), .flush(flush),
    .stall(stall), .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_rdata(rsp_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_rdy(mem_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  logic [31:0]  arch [int];
  logic [127:0] bmem [int];
  bit           m_valid [4];
  bit           m_dirty [4];
  int           m_tag   [4];

  logic [159:0] wb_q [$];
  logic [31:0]  rf_q [$];
  logic [159:0] last_wb [$];
  logic [31:0]  last_rf [$];
  bit           last_hit;
  logic [31:0]  last_rdata;
  bit           mem_auto = 1'b1;

  function automatic logic [31:0] dflt_word(int wa);
    return (32'(wa) * 32'h9E37_79B9) ^ 32'h1000_0000;
  endfunction

  function automatic logic [127:0] bline(int la);
    logic [127:0] l;
    if (bmem.exists(la)) return bmem[la];
    for (int w = 0; w < 4; w++) l[w*32 +: 32] = dflt_word((la >> 2) + w);
    return l;
  endfunction

  function automatic logic [31:0] aword(int wa);
    logic [127:0] l;
    if (arch.exists(wa)) return arch[wa];
    l = bline((wa & ~3) * 4);
    return l[(wa % 4)*32 +: 32];
  endfunction

  function automatic logic [127:0] aline(int la);
    logic [127:0] l;
    for (int w = 0; w < 4; w++) l[w*32 +: 32] = aword((la >> 2) + w);
    return l;
  endfunction

  // Line-wide memory: random 0..3 cycle latency, one mem_rdy pulse per transaction.
  initial begin
    int cnt;
    cnt = -1;
    mem_rdy = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_rdy) begin
        mem_rdy = 1'b0;
        cnt = -1;
      end else if (mem_auto && reset && mem_req) begin
        if (cnt < 0) cnt = $urandom_range(0, 3);
        if (cnt == 0) begin
          if (mem_we) begin
            wb_q.push_back({mem_addr, mem_wdata});
            bmem[int'(mem_addr)] = mem_wdata;
          end else begin
            rf_q.push_back(mem_addr);
            mem_rdata = bline(int'(mem_addr));
          end
          mem_rdy = 1'b1;
          cnt = -1;
        end else begin
          cnt--;
        end
      end else begin
        cnt = -1;
      end
    end
  end

  task automatic wait_idle();
    int cyc;
    cyc = 0;
    while (stall && cyc < 300) begin @(negedge clk); cyc++; end
  endtask

  task automatic do_access(input logic we, input logic byt, input logic [31:0] addr,
                           input logic [31:0] wd, input int hold);
    int idx, tag, wa, bo, cyc;
    bit exp_hit, exp_wb, ok;
    logic [31:0] w, exp_rd, exp_wba, exp_rfa, hold_addr;
    logic [127:0] exp_wbd, hold_data;
    idx = int'((addr >> 4) & 32'h3);
    tag = int'(addr >> 6);
    wa  = int'(addr >> 2);
    bo  = int'(addr & 32'h3);
    exp_hit = m_valid[idx] && (m_tag[idx] == tag);
    exp_wb  = !exp_hit && m_valid[idx] && m_dirty[idx];
    exp_wba = 32'((m_tag[idx] << 6) | (idx << 4));
    exp_rfa = addr & 32'hFFFF_FFF0;
    exp_wbd = exp_wb ? aline(int'(exp_wba)) : '0;
    w = aword(wa);
    exp_rd = byt ? {24'h0, w[bo*8 +: 8]} : w;

    wait_idle();
    req_valid = 1'b1; req_we = we; req_byte = byt; req_addr = addr; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;

    if (hold > 0) begin
      cyc = 0;
      while (!(mem_req && mem_we) && cyc < 50) begin @(negedge clk); cyc++; end
      hold_addr = mem_addr;
      hold_data = mem_wdata;
      ok = mem_req && mem_we;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        if (!mem_req || !mem_we || mem_addr !== hold_addr || mem_wdata !== hold_data ||
            !stall || rsp_valid) ok = 1'b0;
      end
      n_cmp++;
      if (!ok) begin
        n_fail++;
        $display("FAIL wb_hold: req=%b we=%b addr=%h stall=%b rsp_valid=%b, required stable req=1 we=1 addr=%h stall=1 rsp_valid=0",
                 mem_req, mem_we, mem_addr, stall, rsp_valid, hold_addr);
      end
      mem_auto = 1'b1;
    end

    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!rsp_valid && cyc < 300);

    n_cmp++;
    if (!rsp_valid) begin
      n_fail++;
      $display("FAIL rsp_timeout addr=%h: rsp_valid=0 after %0d cycles, required 1", addr, cyc);
    end else begin
      if (rsp_hit !== exp_hit) begin
        n_fail++;
        $display("FAIL rsp_hit addr=%h: got %b required %b", addr, rsp_hit, exp_hit);
      end
      if (exp_hit) begin
        n_cmp++;
        if (cyc != 1) begin
          n_fail++;
          $display("FAIL hit_latency addr=%h: got %0d required 1", addr, cyc);
        end
      end
      if (!we) begin
        n_cmp++;
        if (rsp_rdata !== exp_rd) begin
          n_fail++;
          $display("FAIL rdata addr=%h byte=%b: got %h required %h", addr, byt, rsp_rdata, exp_rd);
        end
      end
    end

    n_cmp++;
    if (wb_q.size() != (exp_wb ? 1 : 0)) begin
      n_fail++;
      $display("FAIL wb_count addr=%h: got %0d required %0d", addr, wb_q.size(), exp_wb ? 1 : 0);
    end else if (exp_wb && wb_q[0] !== {exp_wba, exp_wbd}) begin
      n_fail++;
      $display("FAIL wb_line addr=%h: got %h required %h", addr, wb_q[0], {exp_wba, exp_wbd});
    end
    n_cmp++;
    if (rf_q.size() != (exp_hit ? 0 : 1)) begin
      n_fail++;
      $display("FAIL rf_count addr=%h: got %0d required %0d", addr, rf_q.size(), exp_hit ? 0 : 1);
    end else if (!exp_hit && rf_q[0] !== exp_rfa) begin
      n_fail++;
      $display("FAIL rf_addr: got %h required %h", rf_q[0], exp_rfa);
    end

    last_wb = wb_q; last_rf = rf_q;
    wb_q.delete(); rf_q.delete();
    last_hit = rsp_hit; last_rdata = rsp_rdata;

    if (!exp_hit) begin m_valid[idx] = 1'b1; m_tag[idx] = tag; m_dirty[idx] = 1'b0; end
    if (we) begin
      if (byt) w[bo*8 +: 8] = wd[7:0];
      else     w = wd;
      arch[wa] = w;
      m_dirty[idx] = 1'b1;
    end
  endtask

  task automatic do_flush();
    logic [159:0] exp_q [$];
    logic [31:0] a;
    int cyc;
    bit saw_rsp;
    for (int i = 0; i < 4; i++)
      if (m_valid[i] && m_dirty[i]) begin
        a = 32'((m_tag[i] << 6) | (i << 4));
        exp_q.push_back({a, aline(int'(a))});
      end
    wait_idle();
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    n_cmp++;
    if (stall !== 1'b1) begin n_fail++; $display("FAIL flush_stall: got %b required 1", stall); end
    cyc = 0; saw_rsp = 1'b0;
    do begin
      @(negedge clk); cyc++;
      if (rsp_valid) saw_rsp = 1'b1;
    end while (stall && cyc < 500);
    n_cmp++;
    if (stall || saw_rsp) begin
      n_fail++;
      $display("FAIL flush_done: stall=%b rsp_seen=%b, required 0 0", stall, saw_rsp);
    end
    n_cmp++;
    if (wb_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL flush_wb_count: got %0d required %0d", wb_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) if (wb_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL flush_wb[%0d]: got %h required %h", i, wb_q[i], exp_q[i]);
      end
    end
    last_wb = wb_q;
    wb_q.delete(); rf_q.delete();
    for (int i = 0; i < 4; i++) begin m_valid[i] = 1'b0; m_dirty[i] = 1'b0; end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({stall, rsp_valid, rsp_hit, mem_req, mem_we} !== 5'b0 || rsp_rdata !== 32'h0 ||
        mem_addr !== 32'h0 || mem_wdata !== 128'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: stall=%b rsp=%b hit=%b rdata=%h req=%b we=%b addr=%h, required all 0",
               stall, rsp_valid, rsp_hit, rsp_rdata, mem_req, mem_we, mem_addr);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_miss_then_hit();
    bmem[32'h10] = 128'hAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD;
    do_access(1'b0, 1'b0, 32'h10, 32'h0, 0);
    n_cmp++;
    if (last_hit !== 1'b0 || last_rdata !== 32'hDDDDDDDD || last_rf.size() != 1 || last_rf[0] !== 32'h10) begin
      n_fail++;
      $display("FAIL first_miss: hit=%b rdata=%h, required hit=0 rdata=DDDDDDDD refill@10", last_hit, last_rdata);
    end
    do_access(1'b0, 1'b0, 32'h14, 32'h0, 0);
    n_cmp++;
    if (last_hit !== 1'b1 || last_rdata !== 32'hCCCCCCCC) begin
      n_fail++;
      $display("FAIL reload_hit: hit=%b rdata=%h, required 1 CCCCCCCC", last_hit, last_rdata);
    end
    do_access(1'b0, 1'b0, 32'h1B, 32'h0, 0);
    n_cmp++;
    if (last_rdata !== 32'hBBBBBBBB) begin
      n_fail++;
      $display("FAIL misaligned_word: got %h required BBBBBBBB", last_rdata);
    end
  endtask

  task automatic test_byte_store();
    do_access(1'b1, 1'b1, 32'h13, 32'hFFFF_FF5A, 0);
    do_access(1'b0, 1'b1, 32'h13, 32'h0, 0);
    n_cmp++;
    if (last_rdata !== 32'h0000005A) begin
      n_fail++;
      $display("FAIL byte_load: got %h required 0000005A", last_rdata);
    end
    do_access(1'b0, 1'b0, 32'h10, 32'h0, 0);
    n_cmp++;
    if (last_rdata !== 32'h5ADDDDDD) begin
      n_fail++;
      $display("FAIL merged_word: got %h required 5ADDDDDD", last_rdata);
    end
  endtask

  task automatic test_evict();
    do_access(1'b0, 1'b0, 32'h50, 32'h0, 0);
    n_cmp++;
    if (last_wb.size() != 1 || last_wb[0][159:128] !== 32'h10 || last_wb[0][31:0] !== 32'h5ADDDDDD ||
        last_rf.size() != 1 || last_rf[0] !== 32'h50) begin
      n_fail++;
      $display("FAIL evict_order: wb_count=%0d rf_count=%0d, required wb@10 word0=5ADDDDDD then refill@50",
               last_wb.size(), last_rf.size());
    end
  endtask

  task automatic test_flush();
    do_flush();
    do_access(1'b1, 1'b0, 32'h00, $urandom, 0);
    do_access(1'b1, 1'b1, 32'h21, $urandom, 0);
    do_flush();
    n_cmp++;
    if (last_wb.size() != 2 || last_wb[0][159:128] !== 32'h00 || last_wb[1][159:128] !== 32'h20) begin
      n_fail++;
      $display("FAIL flush_pair: count=%0d, required 2 write-backs at 00 then 20", last_wb.size());
    end
    do_access(1'b0, 1'b0, 32'h04, 32'h0, 0);
    n_cmp++;
    if (last_hit !== 1'b0) begin n_fail++; $display("FAIL post_flush_miss: hit=%b required 0", last_hit); end
  endtask

  task automatic test_wb_hold();
    do_access(1'b1, 1'b0, 32'h54, 32'h1234_5678, 0);
    mem_auto = 1'b0;
    do_access(1'b0, 1'b0, 32'h90, 32'h0, 10);
  endtask

  task automatic test_reset_midop();
    int cyc;
    mem_auto = 1'b0;
    wait_idle();
    req_valid = 1'b1; req_we = 1'b0; req_byte = 1'b0; req_addr = 32'hD0; req_wdata = 32'h0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    cyc = 0;
    while (!(mem_req && !mem_we) && cyc < 50) begin @(negedge clk); cyc++; end
    n_cmp++;
    if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'hD0) begin
      n_fail++;
      $display("FAIL refill_issue: req=%b we=%b addr=%h, required 1 0 000000d0", mem_req, mem_we, mem_addr);
    end
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if (mem_req !== 1'b0 || stall !== 1'b0) begin
      n_fail++;
      $display("FAIL async_abort: mem_req=%b stall=%b, required 0 0", mem_req, stall);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin m_valid[i] = 1'b0; m_dirty[i] = 1'b0; end
    arch.delete(); wb_q.delete(); rf_q.delete();
    mem_auto = 1'b1;
    do_access(1'b0, 1'b0, 32'hD0, 32'h0, 0);
    n_cmp++;
    if (last_hit !== 1'b0) begin n_fail++; $display("FAIL miss_after_reset: hit=%b required 0", last_hit); end
  endtask

  task automatic test_back_to_back();
    do_access(1'b0, 1'b0, 32'hD4, 32'h0, 0);
    do_access(1'b1, 1'b0, 32'hD8, 32'hCAFE_F00D, 0);
    do_access(1'b0, 1'b0, 32'hD8, 32'h0, 0);
    do_access(1'b0, 1'b1, 32'hDA, 32'h0, 0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 250; k++) begin
      if ($urandom_range(0, 15) == 0) do_flush();
      else do_access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     32'($urandom_range(0, 255)), $urandom, 0);
    end
  endtask

  initial begin
    reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_byte = 1'b0;
    req_addr = '0; req_wdata = '0; flush = 1'b0;
    for (int i = 0; i < 4; i++) begin m_valid[i] = 1'b0; m_dirty[i] = 1'b0; m_tag[i] = 0; end
    test_reset();
    test_miss_then_hit();
    test_byte_store();
    test_evict();
    test_flush();
    test_wb_hold();
    test_reset_midop();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
